ram_stream_loader: RTL

RAM_STREAM_LOADER -- requirements
Module: ram_stream_loader

---
 rtl/ram_stream_loader.sv | 116 +++++++++++
 1 files changed

// File: rtl/ram_stream_loader.sv
// Byte-stream to RAM loader: packs little-endian bytes into DATA_WIDTH words,
// issues one write per word and keeps a 16-bit running byte checksum.
module ram_stream_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  abort,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic                  we,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           checksum
);

  localparam int BPW   = DATA_WIDTH / 8;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t                state, state_next;
  logic [IDX_W-1:0]      byte_idx;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   words;
  logic [ADDR_WIDTH:0]   words_next;
  logic [DATA_WIDTH-1:0] buffer;
  logic [DATA_WIDTH-1:0] assembled;
  logic                  can_start;
  logic                  accept;
  logic                  last_byte;

  assign can_start  = start && (state == IDLE || state == DONE);
  assign accept     = (state == COLLECT) && in_valid && !abort;
  assign last_byte  = (byte_idx == IDX_W'(BPW - 1));
  assign words_next = words + 1'b1;

  always_comb begin
    assembled = buffer;
    assembled[8*byte_idx +: 8] = in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_next = (word_count == '0) ? DONE : COLLECT;
      end
      COLLECT: begin
        if (abort)                      state_next = IDLE;
        else if (in_valid && last_byte) state_next = WRITE;
      end
      WRITE: begin
        if (abort)                    state_next = IDLE;
        else if (words_next == count) state_next = DONE;
        else                          state_next = COLLECT;
      end
      default: state_next = IDLE;
    endcase
  end

  // The write strobe is masked by abort and reset so a word caught in WRITE
  // never reaches the RAM when the load is being cancelled that same cycle.
  always_comb begin
    in_ready = (state == COLLECT);
    busy     = (state == COLLECT) || (state == WRITE);
    done     = (state == DONE);
    we       = (state == WRITE) && !abort && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx   <= '0;
      count      <= '0;
      words      <= '0;
      buffer     <= '0;
      data       <= '0;
      write_addr <= '0;
      checksum   <= '0;
    end else if (can_start) begin
      count      <= word_count;
      words      <= '0;
      byte_idx   <= '0;
      write_addr <= '0;
      checksum   <= '0;
    end else begin
      if (accept) begin
        buffer   <= assembled;
        checksum <= checksum + {8'h00, in_data};
        if (last_byte) begin
          byte_idx <= '0;
          data     <= assembled;
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end
      if (state == WRITE && !abort) begin
        write_addr <= write_addr + 1'b1;
        words      <= words_next;
      end
      if (abort && (state == COLLECT || state == WRITE)) byte_idx <= '0;
    end
  end

endmodule
